// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART.
// The parity FSM states exist only when UART_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_t;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_t;
`else
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxStop} tx_state_t;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop} rx_state_t;
`endif

    // Wide enough to index up to 9 payload bits.
    localparam int unsigned BIT_IDX_W = 4;

    function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                   input int unsigned bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO; full/empty derived from the occupancy count.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = count_q == CW'(DEPTH);
    assign empty    = count_q == '0;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign count    = count_q;
    // Head reads as zero when empty so the consumer side resets to a clean value.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_buffered.sv
// FIFO-buffered full-duplex UART with sticky error flags.
// Optional parity bit per frame is enabled by defining UART_PARITY_EN.
module uart_buffered
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BIT_RATE   = 9600,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter bit          PARITY_ODD = 1'b0,
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 uart_rxd,
    output logic                 uart_txd,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [CW-1:0]        tx_count,
    output logic [CW-1:0]        rx_count,
    output logic                 err_overrun,
    output logic                 err_frame,
    output logic                 err_parity,
    input  logic                 err_clear
);

    localparam int unsigned CPB   = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int unsigned CNT_W = $clog2(CPB);
    localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(CPB / 2 - 1);
    localparam logic [BIT_IDX_W-1:0] DATA_LAST = BIT_IDX_W'(DATA_BITS - 1);
    localparam logic                 STOP_LAST = (STOP_BITS == 2);

    // ---------------- TX ----------------
    logic                 tx_full, tx_empty, tx_pop;
    logic [DATA_BITS-1:0] tx_head;
    tx_state_t            tx_state_q;
    logic [CNT_W-1:0]     tx_cnt_q;
    logic [BIT_IDX_W-1:0] tx_idx_q;
    logic                 tx_stop_idx_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic                 txd_q;
    logic                 tx_bit_end;
`ifdef UART_PARITY_EN
    logic                 tx_par_q;
`endif

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (tx_valid),
        .push_data(tx_data),
        .pop      (tx_pop),
        .pop_data (tx_head),
        .count    (tx_count),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    assign tx_ready   = !tx_full;
    assign uart_txd   = txd_q;
    assign tx_bit_end = tx_cnt_q == BIT_LAST;
    // Reload straight from the last stop bit so queued frames go out gap-free.
    assign tx_pop = !tx_empty && (tx_state_q == TxIdle ||
                    (tx_state_q == TxStop && tx_bit_end && tx_stop_idx_q == STOP_LAST));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state_q    <= TxIdle;
            tx_cnt_q      <= '0;
            tx_idx_q      <= '0;
            tx_stop_idx_q <= 1'b0;
            tx_shift_q    <= '0;
            txd_q         <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q      <= 1'b0;
`endif
        end else if (tx_pop) begin
            tx_state_q <= TxStart;
            tx_cnt_q   <= '0;
            tx_shift_q <= tx_head;
            txd_q      <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= ^tx_head ^ PARITY_ODD;
`endif
        end else begin
            tx_cnt_q <= tx_bit_end ? '0 : tx_cnt_q + 1'b1;
            case (tx_state_q)
                TxIdle: begin
                    tx_cnt_q <= '0;
                    txd_q    <= 1'b1;
                end
                TxStart: if (tx_bit_end) begin
                    tx_state_q <= TxData;
                    tx_idx_q   <= '0;
                    txd_q      <= tx_shift_q[0];
                    tx_shift_q <= tx_shift_q >> 1;
                end
                TxData: if (tx_bit_end) begin
                    if (tx_idx_q == DATA_LAST) begin
`ifdef UART_PARITY_EN
                        tx_state_q <= TxParity;
                        txd_q      <= tx_par_q;
`else
                        tx_state_q    <= TxStop;
                        tx_stop_idx_q <= 1'b0;
                        txd_q         <= 1'b1;
`endif
                    end else begin
                        tx_idx_q   <= tx_idx_q + 1'b1;
                        txd_q      <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                    end
                end
`ifdef UART_PARITY_EN
                TxParity: if (tx_bit_end) begin
                    tx_state_q    <= TxStop;
                    tx_stop_idx_q <= 1'b0;
                    txd_q         <= 1'b1;
                end
`endif
                TxStop: if (tx_bit_end) begin
                    if (tx_stop_idx_q == STOP_LAST) tx_state_q <= TxIdle;
                    else                            tx_stop_idx_q <= 1'b1;
                end
                default: tx_state_q <= TxIdle;
            endcase
        end
    end

    // ---------------- RX ----------------
    logic                 rxd_meta_q, rxd_sync_q, rxd_prev_q;
    rx_state_t            rx_state_q;
    logic [CNT_W-1:0]     rx_cnt_q;
    logic [BIT_IDX_W-1:0] rx_idx_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_bit_end, stop_sample, parity_bad, rx_push, rx_full, rx_empty;
    logic                 err_overrun_q, err_frame_q;
`ifdef UART_PARITY_EN
    logic                 rx_par_q;
    logic                 err_parity_q;
`endif

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (rx_push),
        .push_data(rx_shift_q),
        .pop      (rx_ready),
        .pop_data (rx_data),
        .count    (rx_count),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    assign rx_valid    = !rx_empty;
    assign rx_bit_end  = rx_cnt_q == BIT_LAST;
    assign stop_sample = rx_state_q == RxStop && rx_bit_end;
`ifdef UART_PARITY_EN
    assign parity_bad  = ^{rx_shift_q, rx_par_q} ^ PARITY_ODD;
`else
    assign parity_bad  = 1'b0;
`endif
    // A full FIFO silently ignores the push; the overrun flag records the loss.
    assign rx_push     = stop_sample && rxd_sync_q && !parity_bad;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
`ifdef UART_PARITY_EN
            rx_par_q   <= 1'b0;
`endif
        end else begin
            rx_cnt_q <= rx_bit_end ? '0 : rx_cnt_q + 1'b1;
            case (rx_state_q)
                RxIdle: begin
                    rx_cnt_q <= '0;
                    if (rxd_prev_q && !rxd_sync_q) rx_state_q <= RxStart;
                end
                RxStart: if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_q   <= '0;
                    rx_idx_q   <= '0;
                    rx_state_q <= rxd_sync_q ? RxIdle : RxData;
                end
                RxData: if (rx_bit_end) begin
                    rx_shift_q <= {rxd_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_idx_q   <= rx_idx_q + 1'b1;
                    if (rx_idx_q == DATA_LAST) begin
`ifdef UART_PARITY_EN
                        rx_state_q <= RxParity;
`else
                        rx_state_q <= RxStop;
`endif
                    end
                end
`ifdef UART_PARITY_EN
                RxParity: if (rx_bit_end) begin
                    rx_par_q   <= rxd_sync_q;
                    rx_state_q <= RxStop;
                end
`endif
                RxStop: if (rx_bit_end) rx_state_q <= RxIdle;
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    // Sticky flags: a new event in the clear cycle wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_overrun_q <= 1'b0;
            err_frame_q   <= 1'b0;
`ifdef UART_PARITY_EN
            err_parity_q  <= 1'b0;
`endif
        end else begin
            err_overrun_q <= (rx_push && rx_full) || (err_overrun_q && !err_clear);
            err_frame_q   <= (stop_sample && !rxd_sync_q) || (err_frame_q && !err_clear);
`ifdef UART_PARITY_EN
            err_parity_q  <= (stop_sample && rxd_sync_q && parity_bad) ||
                             (err_parity_q && !err_clear);
`endif
        end
    end

    assign err_overrun = err_overrun_q;
    assign err_frame   = err_frame_q;
`ifdef UART_PARITY_EN
    assign err_parity  = err_parity_q;
`else
    assign err_parity  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_buffered.sv
// Scoreboard bench for uart_buffered at CPB=10, 8N1 (8E1 when UART_PARITY_EN is defined).
module tb_uart_buffered;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       uart_txd;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [4:0] tx_count, rx_count;
    logic       err_overrun, err_frame, err_parity;
    logic       err_clear = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];

    uart_buffered #(
        .DATA_BITS (8),
        .CLK_HZ    (1_000_000),
        .BIT_RATE  (100_000),
        .STOP_BITS (1),
        .FIFO_DEPTH(16),
        .PARITY_ODD(1'b0)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .uart_rxd   (uart_rxd),
        .uart_txd   (uart_txd),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_count   (tx_count),
        .rx_count   (rx_count),
        .err_overrun(err_overrun),
        .err_frame  (err_frame),
        .err_parity (err_parity),
        .err_clear  (err_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tx_exp_q.push_back(b);
        step(1);
        tx_valid = 1'b0;
    endtask

    // Start bit, data LSB first, [parity], one stop bit; par_flip corrupts parity.
    task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit,
                                  input logic par_flip);
        logic [10:0] bits;
        int nb;
`ifdef UART_PARITY_EN
        nb   = 11;
        bits = {stop_bit, ^b ^ par_flip, b, 1'b0};
`else
        nb   = 10;
        bits = {par_flip, stop_bit, b, 1'b0};
`endif
        for (int i = 0; i < nb; i++) begin
            uart_rxd = bits[i];
            step(CPB);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic test_reset;
        n_cmp++; if (uart_txd !== 1'b1) begin n_err++; $display("FAIL reset_txd: got %b want 1", uart_txd); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        n_cmp++; if (tx_count !== 5'd0 || rx_count !== 5'd0) begin
            n_err++; $display("FAIL reset_counts: got tx=%0d rx=%0d want 0/0", tx_count, rx_count);
        end
        n_cmp++; if ({err_overrun, err_frame, err_parity} !== 3'b000) begin
            n_err++; $display("FAIL reset_errs: got %b want 000", {err_overrun, err_frame, err_parity});
        end
    endtask

    task automatic test_tx_single;
        logic [7:0] b;
        logic [9:0] frame;
        push_tx(8'hA5);
        n_cmp++; if (uart_txd !== 1'b1 || tx_count !== 5'd1) begin
            n_err++; $display("FAIL tx_latency_c1: got txd=%b cnt=%0d want 1/1", uart_txd, tx_count);
        end
        step(1);
        b = tx_exp_q.pop_front();
        frame = {1'b1, b, 1'b0};
        n_cmp++; if (tx_count !== 5'd0) begin n_err++; $display("FAIL tx_pop_count: got %0d want 0", tx_count); end
        for (int j = 0; j < 10 * CPB; j++) begin
            n_cmp++;
            if (uart_txd !== frame[j / CPB]) begin
                n_err++; $display("FAIL tx_a5 cyc %0d: got %b want %b", j, uart_txd, frame[j / CPB]);
            end
            step(1);
        end
        n_cmp++; if (uart_txd !== 1'b1) begin n_err++; $display("FAIL tx_a5_idle: got %b want 1", uart_txd); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b;
        logic [9:0] frame;
        push_tx(8'h01);
        push_tx(8'h02);
        push_tx(8'h03);
        // The idle transmitter took the first byte one cycle after it landed.
        n_cmp++; if (tx_count !== 5'd2) begin n_err++; $display("FAIL b2b_count0: got %0d want 2", tx_count); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (tx_exp_q.size() == 0) begin
                n_err++; $display("FAIL b2b_queue: got empty want byte %0d", k);
                return;
            end
            b = tx_exp_q.pop_front();
            frame = {1'b1, b, 1'b0};
            for (int j = (k == 0) ? 1 : 0; j < 10 * CPB; j++) begin
                if (j == 0) begin
                    n_cmp++;
                    if (tx_count !== 5'(tx_exp_q.size())) begin
                        n_err++; $display("FAIL b2b_count frame %0d: got %0d want %0d", k, tx_count, tx_exp_q.size());
                    end
                end
                n_cmp++;
                if (uart_txd !== frame[j / CPB]) begin
                    n_err++; $display("FAIL b2b frame %0d cyc %0d: got %b want %b", k, j, uart_txd, frame[j / CPB]);
                end
                step(1);
            end
        end
        for (int j = 0; j < 5; j++) begin
            n_cmp++;
            if (uart_txd !== 1'b1 || tx_count !== 5'd0) begin
                n_err++; $display("FAIL b2b_idle: got txd=%b cnt=%0d want 1/0", uart_txd, tx_count);
            end
            step(1);
        end
    endtask

    task automatic test_rx_overrun;
        logic [7:0] b;
        rx_ready = 1'b0;
        rx_exp_q.push_back(8'h3C);
        drive_rx_frame(8'h3C, 1'b1, 1'b0);
        step(2);
        n_cmp++; if (rx_valid !== 1'b1 || rx_count !== 5'd1) begin
            n_err++; $display("FAIL rx_first: got valid=%b cnt=%0d want 1/1", rx_valid, rx_count);
        end
        n_cmp++; if (rx_data !== rx_exp_q[0]) begin n_err++; $display("FAIL rx_first_data: got %h want %h", rx_data, rx_exp_q[0]); end
        step(5);
        n_cmp++; if (rx_data !== rx_exp_q[0]) begin n_err++; $display("FAIL rx_stable: got %h want %h", rx_data, rx_exp_q[0]); end
        for (int i = 1; i <= 16; i++) begin
            b = 8'(i * 17 + 3);
            if (i <= 15) rx_exp_q.push_back(b);
            drive_rx_frame(b, 1'b1, 1'b0);
            if (i == 15) begin
                n_cmp++;
                if (rx_count !== 5'd16 || err_overrun !== 1'b0) begin
                    n_err++; $display("FAIL rx_full: got cnt=%0d ovr=%b want 16/0", rx_count, err_overrun);
                end
            end
        end
        step(2);
        n_cmp++; if (err_overrun !== 1'b1 || rx_count !== 5'd16) begin
            n_err++; $display("FAIL rx_overrun: got ovr=%b cnt=%0d want 1/16", err_overrun, rx_count);
        end
        n_cmp++; if (rx_data !== rx_exp_q[0]) begin n_err++; $display("FAIL rx_head_kept: got %h want %h", rx_data, rx_exp_q[0]); end
        rx_ready = 1'b1;
        for (int i = 0; i < 40 && rx_exp_q.size() > 0; i++) begin
            if (rx_valid) begin
                b = rx_exp_q.pop_front();
                n_cmp++;
                if (rx_data !== b) begin n_err++; $display("FAIL rx_drain: got %h want %h", rx_data, b); end
            end
            step(1);
        end
        rx_ready = 1'b0;
        n_cmp++; if (rx_exp_q.size() != 0 || rx_count !== 5'd0 || rx_valid !== 1'b0) begin
            n_err++; $display("FAIL rx_drained: got left=%0d cnt=%0d valid=%b want 0/0/0", rx_exp_q.size(), rx_count, rx_valid);
        end
    endtask

    task automatic test_frame_err;
        drive_rx_frame(8'h81, 1'b0, 1'b0);
        step(3);
        n_cmp++; if (err_frame !== 1'b1 || rx_count !== 5'd0) begin
            n_err++; $display("FAIL frame_err: got err=%b cnt=%0d want 1/0", err_frame, rx_count);
        end
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        n_cmp++; if ({err_overrun, err_frame, err_parity} !== 3'b000) begin
            n_err++; $display("FAIL err_clear: got %b want 000", {err_overrun, err_frame, err_parity});
        end
    endtask

    task automatic test_glitch;
        logic [7:0] b;
        uart_rxd = 1'b0;
        step(3);
        uart_rxd = 1'b1;
        step(30);
        n_cmp++; if (rx_count !== 5'd0 || {err_overrun, err_frame, err_parity} !== 3'b000) begin
            n_err++; $display("FAIL glitch: got cnt=%0d errs=%b want 0/000", rx_count, {err_overrun, err_frame, err_parity});
        end
        rx_exp_q.push_back(8'h5A);
        drive_rx_frame(8'h5A, 1'b1, 1'b0);
        step(2);
        b = rx_exp_q.pop_front();
        n_cmp++; if (rx_valid !== 1'b1 || rx_data !== b) begin
            n_err++; $display("FAIL glitch_recover: got valid=%b data=%h want 1/%h", rx_valid, rx_data, b);
        end
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity;
        logic [7:0] b;
        drive_rx_frame(8'h07, 1'b1, 1'b1);
        step(2);
        n_cmp++; if (err_parity !== 1'b1 || rx_count !== 5'd0) begin
            n_err++; $display("FAIL parity_bad: got err=%b cnt=%0d want 1/0", err_parity, rx_count);
        end
        rx_exp_q.push_back(8'h07);
        drive_rx_frame(8'h07, 1'b1, 1'b0);
        step(2);
        b = rx_exp_q.pop_front();
        n_cmp++; if (rx_count !== 5'd1 || rx_data !== b) begin
            n_err++; $display("FAIL parity_good: got cnt=%0d data=%h want 1/%h", rx_count, rx_data, b);
        end
        rx_ready = 1'b1;
        err_clear = 1'b1;
        step(1);
        rx_ready = 1'b0;
        err_clear = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_tx;
        push_tx(8'h00);
        push_tx(8'h55);
        step(30);
        n_cmp++; if (uart_txd !== 1'b0) begin n_err++; $display("FAIL mid_tx_low: got %b want 0", uart_txd); end
        resetn = 1'b0;
        #1;
        n_cmp++; if (uart_txd !== 1'b1 || tx_count !== 5'd0 || tx_ready !== 1'b1) begin
            n_err++; $display("FAIL async_reset: got txd=%b cnt=%0d rdy=%b want 1/0/1", uart_txd, tx_count, tx_ready);
        end
        tx_exp_q.delete();
        step(2);
        resetn = 1'b1;
        for (int j = 0; j < 3 * CPB; j++) begin
            n_cmp++;
            if (uart_txd !== 1'b1) begin n_err++; $display("FAIL post_reset_idle cyc %0d: got %b want 1", j, uart_txd); end
            step(1);
        end
    endtask

    initial begin
        step(3);
        resetn = 1'b1;
        step(2);
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx_overrun();
        test_frame_err();
        test_glitch();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_reset_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
